// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and payload type for the register-file write path.
//   REG_ADDR_W : register address width (5 -> 32 architectural registers)
//   N_REG      : number of architectural registers, register 0 reads as zero
//   DATA_W     : default register data width
//   wb_req_t   : one write-port request {we, waddr, wdata}
//   REG_ZERO   : address of the constant-zero register
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned N_REG      = 32;
  localparam int unsigned DATA_W     = 16;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = REG_ADDR_W'(0);

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [DATA_W-1:0]     wdata;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO holding multiplier results until the write port is free.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push_i    : write din_i at the tail (ignored when full)
//   pop_i     : drop the head entry (ignored when empty)
//   din_i     : entry to push
//   full_o    : no room for another entry
//   empty_o   : no valid entry
//   head_o    : oldest entry, valid while !empty_o
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; simultaneous push/pop leaves count unchanged.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between the
// pipeline writeback (always wins) and buffered multiplier results, and keeps a
// pending scoreboard of in-flight multiplier destinations to stall decode.
//   clk, rst                  : clock, synchronous active-high reset
//   pipe_we/waddr/wdata       : pipeline writeback request
//   mu_valid/waddr/wdata      : multiplier result offer; mu_ready accepts it
//   issue_valid/issue_waddr   : multiplier op issued, marks destination pending
//   chk_raddr_1/2, chk_waddr  : decode operands checked against pending
//   stall                     : decode must hold (RAW/WAW on pending register)
//   rf_reg_write/waddr/wdata  : to register_file write port
// Optional macro WB_BYPASS_EN: a result arriving with the FIFO empty and the
// pipe not granted is written straight through in the same cycle.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W     = regfile_pkg::DATA_W,
  parameter int unsigned N_REG      = regfile_pkg::N_REG,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0]     pipe_wdata,
  input  logic                  mu_valid,
  output logic                  mu_ready,
  input  logic [REG_ADDR_W-1:0] mu_waddr,
  input  logic [DATA_W-1:0]     mu_wdata,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_waddr,
  input  logic [REG_ADDR_W-1:0] chk_raddr_1,
  input  logic [REG_ADDR_W-1:0] chk_raddr_2,
  input  logic [REG_ADDR_W-1:0] chk_waddr,
  output logic                  stall,
  output logic                  rf_reg_write,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata
);

  localparam int unsigned ENTRY_W = REG_ADDR_W + DATA_W;

  logic                  pipe_grant;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  bypass;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [REG_ADDR_W-1:0] head_waddr;
  logic [DATA_W-1:0]     head_wdata;
  logic [N_REG-1:0]      pending_q, pending_d;

  assign {head_waddr, head_wdata} = fifo_head;

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   ({mu_waddr, mu_wdata}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // Write-port grant: pipe first, then FIFO head, then (optionally) a live result.
  always_comb begin
    pipe_grant   = !rst && pipe_we && (pipe_waddr != REG_ZERO);
    fifo_pop     = !rst && !pipe_grant && !fifo_empty;
`ifdef WB_BYPASS_EN
    bypass       = !rst && !pipe_grant && fifo_empty && mu_valid;
`else
    bypass       = 1'b0;
`endif
    // Readiness depends only on occupancy, never on this cycle's pop.
    mu_ready     = !rst && !fifo_full;
    fifo_push    = mu_valid && mu_ready && !bypass;
    rf_reg_write = 1'b0;
    rf_waddr     = REG_ZERO;
    rf_wdata     = '0;
    if (pipe_grant) begin
      rf_reg_write = 1'b1;
      rf_waddr     = pipe_waddr;
      rf_wdata     = pipe_wdata;
    end else if (fifo_pop) begin
      rf_reg_write = (head_waddr != REG_ZERO);
      rf_waddr     = head_waddr;
      rf_wdata     = head_wdata;
    end else if (bypass) begin
      rf_reg_write = (mu_waddr != REG_ZERO);
      rf_waddr     = mu_waddr;
      rf_wdata     = mu_wdata;
    end
  end

  // Pending scoreboard: retire clears first so a same-cycle issue wins.
  always_comb begin
    pending_d = pending_q;
    if (fifo_pop) pending_d[head_waddr] = 1'b0;
    if (bypass)   pending_d[mu_waddr]   = 1'b0;
    if (issue_valid && (issue_waddr != REG_ZERO)) pending_d[issue_waddr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  // Stall reads registered pending only, so no path from the mu_* inputs.
  assign stall = !rst && (pending_q[chk_raddr_1] | pending_q[chk_raddr_2] |
                          pending_q[chk_waddr]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with a write-port scoreboard.
// Expected register-file writes are queued by the stimulus in the order they
// must appear; a monitor pops and compares on every rf_reg_write.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  pipe_we;
  logic [REG_ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0]     pipe_wdata;
  logic                  mu_valid;
  logic                  mu_ready;
  logic [REG_ADDR_W-1:0] mu_waddr;
  logic [DATA_W-1:0]     mu_wdata;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_waddr;
  logic [REG_ADDR_W-1:0] chk_raddr_1;
  logic [REG_ADDR_W-1:0] chk_raddr_2;
  logic [REG_ADDR_W-1:0] chk_waddr;
  logic                  stall;
  logic                  rf_reg_write;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;

  int      n_checks = 0;
  int      n_fail   = 0;
  wb_req_t exp_q[$];
  wb_req_t mon_e;

  regfile_wb_arbiter #(
    .DATA_W     (DATA_W),
    .N_REG      (N_REG),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_we      (pipe_we),
    .pipe_waddr   (pipe_waddr),
    .pipe_wdata   (pipe_wdata),
    .mu_valid     (mu_valid),
    .mu_ready     (mu_ready),
    .mu_waddr     (mu_waddr),
    .mu_wdata     (mu_wdata),
    .issue_valid  (issue_valid),
    .issue_waddr  (issue_waddr),
    .chk_raddr_1  (chk_raddr_1),
    .chk_raddr_2  (chk_raddr_2),
    .chk_waddr    (chk_waddr),
    .stall        (stall),
    .rf_reg_write (rf_reg_write),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [REG_ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_req_t e;
    e.we    = 1'b1;
    e.waddr = a;
    e.wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we     = 1'b0;
    pipe_waddr  = '0;
    pipe_wdata  = '0;
    mu_valid    = 1'b0;
    mu_waddr    = '0;
    mu_wdata    = '0;
    issue_valid = 1'b0;
    issue_waddr = '0;
    chk_raddr_1 = '0;
    chk_raddr_2 = '0;
    chk_waddr   = '0;
  endtask

  task automatic drive_pipe(input logic we, input logic [REG_ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pipe_we    = we;
    pipe_waddr = a;
    pipe_wdata = d;
  endtask

  task automatic drive_mu(input logic v, input logic [REG_ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    mu_valid = v;
    mu_waddr = a;
    mu_wdata = d;
  endtask

  // Monitor: every write presented to the register file must match the queue head.
  always @(negedge clk) begin
    if (!rst && rf_reg_write) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rf_write: got r%0d=0x%0h, expected no write (t=%0t)", rf_waddr, rf_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_waddr !== mon_e.waddr || rf_wdata !== mon_e.wdata) begin
          n_fail++;
          $display("FAIL rf_write: got r%0d=0x%0h, expected r%0d=0x%0h (t=%0t)",
                   rf_waddr, rf_wdata, mon_e.waddr, mon_e.wdata, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with both writers active and an issue pending: all outputs held low.
    idle_inputs();
    rst = 1'b1;
    drive_pipe(1'b1, 5'd3, 16'h1234);
    drive_mu(1'b1, 5'd9, 16'h9999);
    issue_valid = 1'b1;
    issue_waddr = 5'd9;
    chk_raddr_1 = 5'd9;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_bit("reset_rf_reg_write", rf_reg_write, 1'b0);
      chk_bit("reset_mu_ready", mu_ready, 1'b0);
      chk_bit("reset_stall", stall, 1'b0);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    idle_inputs();

    // After reset: FIFO empty, nothing pending anywhere.
    @(negedge clk);
    chk_bit("post_reset_no_write", rf_reg_write, 1'b0);
    chk_bit("post_reset_mu_ready", mu_ready, 1'b1);
    tick();
    for (int i = 0; i < 32; i++) begin
      chk_raddr_1 = 5'(i);
      chk_raddr_2 = 5'(31 - i);
      chk_waddr   = 5'(i);
      @(negedge clk);
      chk_bit("post_reset_pending_clear", stall, 1'b0);
      tick();
    end
    idle_inputs();

    // Collision: pipe wins, multiplier result pushed and written next cycle.
    drive_pipe(1'b1, 5'd5, 16'h1111);
    drive_mu(1'b1, 5'd7, 16'h2222);
    expect_wr(5'd5, 16'h1111);
    @(negedge clk);
    chk_bit("collision_mu_ready", mu_ready, 1'b1);
    tick();
    idle_inputs();
    expect_wr(5'd7, 16'h2222);
    @(negedge clk);
    chk_bit("collision_mu_write_n1", rf_reg_write, 1'b1);
    chk_val("collision_mu_waddr_n1", 32'(rf_waddr), 32'd7);
    tick();
    @(negedge clk);
    chk_bit("collision_drained", rf_reg_write, 1'b0);
    tick();

    // Full FIFO under a continuous pipe stream, then drain in order.
    drive_pipe(1'b1, 5'd3, 16'h3001);
    drive_mu(1'b1, 5'd8, 16'h0808);
    expect_wr(5'd3, 16'h3001);
    @(negedge clk);
    chk_bit("full_ready_0", mu_ready, 1'b1);
    tick();
    drive_pipe(1'b1, 5'd3, 16'h3002);
    drive_mu(1'b1, 5'd9, 16'h0909);
    expect_wr(5'd3, 16'h3002);
    @(negedge clk);
    chk_bit("full_ready_1", mu_ready, 1'b1);
    tick();
    drive_pipe(1'b1, 5'd3, 16'h3003);
    drive_mu(1'b1, 5'd10, 16'h0A0A);
    expect_wr(5'd3, 16'h3003);
    @(negedge clk);
    chk_bit("full_ready_2", mu_ready, 1'b0);
    tick();
    drive_pipe(1'b1, 5'd3, 16'h3004);
    expect_wr(5'd3, 16'h3004);
    @(negedge clk);
    chk_bit("full_ready_3", mu_ready, 1'b0);
    tick();
    drive_pipe(1'b0, 5'd0, 16'h0000);
    expect_wr(5'd8, 16'h0808);
    @(negedge clk);
    chk_bit("full_ready_during_pop", mu_ready, 1'b0);
    tick();
    expect_wr(5'd9, 16'h0909);
    @(negedge clk);
    chk_bit("full_ready_after_pop", mu_ready, 1'b1);
    tick();
    drive_mu(1'b0, 5'd0, 16'h0000);
    expect_wr(5'd10, 16'h0A0A);
    @(negedge clk);
    chk_bit("full_last_write", rf_reg_write, 1'b1);
    tick();
    @(negedge clk);
    chk_bit("full_drained", rf_reg_write, 1'b0);
    tick();

    // Scoreboard: issue r12, stall on RAW/WAW until the result retires.
    issue_valid = 1'b1;
    issue_waddr = 5'd12;
    chk_raddr_1 = 5'd12;
    @(negedge clk);
    chk_bit("sb_issue_cycle_no_stall", stall, 1'b0);
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    chk_bit("sb_stall_raw1", stall, 1'b1);
    chk_raddr_1 = 5'd0;
    chk_raddr_2 = 5'd12;
    #1;
    chk_bit("sb_stall_raw2", stall, 1'b1);
    chk_raddr_2 = 5'd0;
    chk_waddr   = 5'd12;
    #1;
    chk_bit("sb_stall_waw", stall, 1'b1);
    chk_waddr = 5'd0;
    #1;
    chk_bit("sb_x0_no_stall", stall, 1'b0);
    chk_raddr_1 = 5'd12;
    tick();
    drive_mu(1'b1, 5'd12, 16'h0C0C);
    expect_wr(5'd12, 16'h0C0C);
    @(negedge clk);
    chk_bit("sb_stall_result_arrives", stall, 1'b1);
    tick();
    drive_mu(1'b0, 5'd0, 16'h0000);
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk_bit("sb_stall_after_bypass", stall, 1'b0);
`else
    chk_bit("sb_stall_during_pop", stall, 1'b1);
`endif
    tick();
    @(negedge clk);
    chk_bit("sb_stall_released", stall, 1'b0);
    chk_raddr_1 = 5'd0;
    chk_waddr   = 5'd12;
    #1;
    chk_bit("sb_waw_released", stall, 1'b0);
    tick();

    // Set wins over clear when r13 is reissued in the cycle its result retires.
    chk_waddr   = 5'd0;
    chk_raddr_1 = 5'd13;
    issue_valid = 1'b1;
    issue_waddr = 5'd13;
    tick();
    drive_mu(1'b1, 5'd13, 16'h0D0D);
    expect_wr(5'd13, 16'h0D0D);
`ifdef WB_BYPASS_EN
    issue_valid = 1'b1;
`else
    issue_valid = 1'b0;
`endif
    @(negedge clk);
    chk_bit("sb_r13_pending", stall, 1'b1);
    tick();
    drive_mu(1'b0, 5'd0, 16'h0000);
`ifdef WB_BYPASS_EN
    issue_valid = 1'b0;
`else
    issue_valid = 1'b1;
`endif
    @(negedge clk);
    chk_bit("sb_r13_pending_2", stall, 1'b1);
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    chk_bit("sb_set_wins", stall, 1'b1);
    tick();
    drive_mu(1'b1, 5'd13, 16'h0D0E);
    expect_wr(5'd13, 16'h0D0E);
    tick();
    drive_mu(1'b0, 5'd0, 16'h0000);
    tick();
    @(negedge clk);
    chk_bit("sb_r13_cleared", stall, 1'b0);
    tick();
    chk_raddr_1 = 5'd0;

    // x0: result to r0 is consumed silently; a pipe write to r0 does not block pops.
    drive_pipe(1'b1, 5'd0, 16'hDEAD);
    drive_mu(1'b1, 5'd0, 16'hFFFF);
    @(negedge clk);
    chk_bit("x0_no_write_0", rf_reg_write, 1'b0);
    tick();
    drive_mu(1'b0, 5'd0, 16'h0000);
    @(negedge clk);
    chk_bit("x0_no_write_1", rf_reg_write, 1'b0);
    tick();
    drive_mu(1'b1, 5'd6, 16'h0606);
    expect_wr(5'd6, 16'h0606);
    tick();
    drive_mu(1'b0, 5'd0, 16'h0000);
    tick();
    drive_pipe(1'b0, 5'd0, 16'h0000);
    @(negedge clk);
    chk_bit("x0_fifo_drained", rf_reg_write, 1'b0);
    tick();

    // Latency of a lone result with FIFO empty and pipe idle.
    drive_mu(1'b1, 5'd4, 16'hABCD);
    expect_wr(5'd4, 16'hABCD);
    @(negedge clk);
    chk_bit("lat_mu_ready", mu_ready, 1'b1);
`ifdef WB_BYPASS_EN
    chk_bit("lat_same_cycle_write", rf_reg_write, 1'b1);
    chk_val("lat_same_cycle_waddr", 32'(rf_waddr), 32'd4);
`else
    chk_bit("lat_no_same_cycle_write", rf_reg_write, 1'b0);
`endif
    tick();
    drive_mu(1'b0, 5'd0, 16'h0000);
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk_bit("lat_fifo_stayed_empty", rf_reg_write, 1'b0);
`else
    chk_bit("lat_next_cycle_write", rf_reg_write, 1'b1);
    chk_val("lat_next_cycle_wdata", 32'(rf_wdata), 32'h0000ABCD);
`endif
    tick();
    @(negedge clk);
    chk_bit("lat_idle", rf_reg_write, 1'b0);
    tick();

    chk_val("all_expected_writes_seen", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of register_file and shares it between two writers: the in-order pipeline writeback and the multi-cycle multiplier (MULT4) result.
- Pipeline writes always win. Multiplier results wait in a small FIFO until the port is free.
- A per-register pending scoreboard tracks multiplier destinations still in flight and drives a stall to decode for RAW/WAW hazards.

Parameters:
- DATA_W, 16, data width of the register file.
- N_REG, 32, number of architectural registers; register 0 is constant zero.
- FIFO_DEPTH, 2, number of buffered multiplier results; power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- pipe_we  in  1  pipeline writeback valid.
- pipe_waddr  in  5  pipeline destination register.
- pipe_wdata  in  DATA_W  pipeline writeback data.
- mu_valid  in  1  multiplier result valid.
- mu_ready  out  1  multiplier result accepted this cycle.
- mu_waddr  in  5  multiplier destination register.
- mu_wdata  in  DATA_W  multiplier result data.
- issue_valid  in  1  a multiplier op is issued this cycle.
- issue_waddr  in  5  destination register of the issued op.
- chk_raddr_1  in  5  decode source register 1.
- chk_raddr_2  in  5  decode source register 2.
- chk_waddr  in  5  decode destination register.
- stall  out  1  decode must hold.
- rf_reg_write  out  1  to register_file reg_write.
- rf_waddr  out  5  to register_file waddr.
- rf_wdata  out  DATA_W  to register_file wdata.

Behaviour:
- Reset, taken at posedge clk while rst=1:
  - FIFO empty (rd_ptr = wr_ptr = count = 0).
  - pending[] all 0.
  - While rst=1: rf_reg_write=0, mu_ready=0, stall=0.
- Write-port grant, combinational, per cycle:
  - pipe_we=1 and pipe_waddr≠0: pipe granted. rf_* = pipe fields.
  - Otherwise, FIFO non-empty: FIFO head granted (pop). rf_reg_write=1 only if head waddr≠0.
  - Otherwise: rf_reg_write=0, rf_waddr=0, rf_wdata=0.
  - A pipe write to x0 never consumes the port.
- FIFO:
  - mu_ready = !full; it does not depend on a same-cycle pop.
  - Push when mu_valid & mu_ready.
  - Push and pop in the same cycle: count unchanged, pointers each advance and wrap modulo FIFO_DEPTH.
  - mu_valid while full: result is held by the multiplier, not dropped.
  - Base latency: a result accepted in cycle N reaches rf_* no earlier than cycle N+1.
- Scoreboard:
  - issue_valid with issue_waddr≠0 sets pending[issue_waddr] at the next edge.
  - A FIFO pop with head waddr=r clears pending[r] at the next edge.
  - Set and clear of the same register in the same cycle: set wins.
  - pending[0] is hard-wired 0.
- stall = pending[chk_raddr_1] | pending[chk_raddr_2] | pending[chk_waddr]. This covers RAW and WAW against in-flight multiplier results.
  - Combinational from registered state, so it has no combinational path from the mu_* inputs.
- Port starvation: the pipeline is never back-pressured. The multiplier is throttled only via mu_ready. Decode must use stall to create bubbles.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when FIFO empty, pipe not granted and mu_valid=1, the result is written to rf_* in the same cycle without a push (latency 0). pending for that register clears at that edge. mu_ready=1 in that case.
- Undefined: every result goes through the FIFO (latency ≥1).

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ADDR_W=5, N_REG=32, DATA_W default.
  - wb_req_t struct {we, waddr, wdata}.
  - Constant REG_ZERO=5'd0.
- One natural sub-module: wb_fifo (parameterised synchronous FIFO with push/pop/full/empty/head). Arbitration, scoreboard and stall stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with mu_valid=1, pipe_we=1 → rf_reg_write=0, mu_ready=0, stall=0. After release, pending all 0 and FIFO empty.
- Collision: cycle N pipe_we=1, waddr=5, wdata=0x1111, plus mu_valid, waddr=7, wdata=0x2222.
  - Cycle N: rf writes r5=0x1111 and the mu result is pushed.
  - Cycle N+1, pipe idle: rf writes r7=0x2222.
- Full FIFO: pipe_we=1 (waddr=3) every cycle, mu_valid held with waddr 8, 9, 10 → mu_ready drops after 2 pushes. Releasing pipe_we drains r8 then r9 in order, then accepts r10.
- Scoreboard: issue_valid with issue_waddr=12, then chk_raddr_1=12 → stall=1 until the cycle after r12 is popped to the RF, then 0. Same result with chk_waddr=12. chk_raddr=0 never stalls.
- x0: mu result waddr=0, data=0xFFFF → popped with rf_reg_write=0 and no pending change. pipe_we=1 with waddr=0 does not block a FIFO pop in the same cycle.
- WB_BYPASS_EN: FIFO empty, pipe idle, mu_valid waddr=4, data=0xABCD → rf_reg_write=1, r4=0xABCD in the same cycle, count stays 0. Without the macro, the write lands one cycle later.
